// File: rtl/pad_ai_controller.sv
// rtl/pad_ai_controller.sv - computer opponent driving the right paddle from ball position
// Updates only on timing_tick; CENTER/WAIT/TRACK FSM with rate-limited, clamped motion.
module pad_ai_controller #(
    parameter int PAD_HEIGHT  = 72,
    parameter int BALL_SIZE   = 15,
    parameter int SCREEN_H    = 768,
    parameter int SCREEN_W    = 1024,
    parameter int PAD_SPEED   = 2,
    parameter int DEAD_ZONE   = 4,
    parameter int REACT_TICKS = 8,
    parameter int TRACK_X     = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        enable,
    input  logic [10:0] x_ball,
    input  logic [10:0] y_ball,
    output logic [9:0]  y_pad_right,
    output logic        approaching
);

    localparam int PAD_MAX    = SCREEN_H - PAD_HEIGHT;
    localparam int CENTER_Y   = PAD_MAX / 2;
    localparam int X_PREV_RST = (SCREEN_W - BALL_SIZE - 1) / 2;
    localparam int CNT_W      = $clog2(REACT_TICKS + 1);

    localparam logic signed [11:0] PAD_MAX_S  = 12'(PAD_MAX);
    localparam logic signed [11:0] CENTER_S   = 12'(CENTER_Y);
    localparam logic signed [11:0] TGT_OFS_S  = 12'(PAD_HEIGHT / 2 - BALL_SIZE / 2);
    localparam logic signed [11:0] SPEED_S    = 12'(PAD_SPEED);
    localparam logic signed [11:0] DEAD_S     = 12'(DEAD_ZONE);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(REACT_TICKS - 1);
    localparam logic [10:0]        TRACK_X_U  = 11'(TRACK_X);

    typedef enum logic [1:0] {
        ST_CENTER,
        ST_WAIT,
        ST_TRACK
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   react_cnt, react_cnt_nxt;
    logic [10:0]        x_prev;
    logic               appr_nxt;

    logic signed [11:0] track_raw, track_tgt, target;
    logic signed [11:0] pad_s, err, abs_err, step, moved, moved_clamped;
    logic               move_en;
    logic [9:0]         pad_nxt;

    // Direction is judged against the previous tick's x; equal x keeps the last verdict.
    always_comb begin
        appr_nxt = approaching;
        if (x_ball > x_prev) begin
            appr_nxt = 1'b1;
        end else if (x_ball < x_prev) begin
            appr_nxt = 1'b0;
        end
    end

    always_comb begin
        state_nxt     = state;
        react_cnt_nxt = react_cnt;
        if (!enable) begin
            state_nxt     = ST_CENTER;
            react_cnt_nxt = '0;
        end else begin
            case (state)
                ST_CENTER: begin
                    if (appr_nxt && (x_ball >= TRACK_X_U)) begin
                        state_nxt     = ST_WAIT;
                        react_cnt_nxt = '0;
                    end
                end
                ST_WAIT: begin
                    if (!appr_nxt) begin
                        state_nxt = ST_CENTER;
                    end else if (react_cnt == CNT_LAST) begin
                        state_nxt = ST_TRACK;
                    end else begin
                        react_cnt_nxt = react_cnt + 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (!appr_nxt) begin
                        state_nxt = ST_CENTER;
                    end
                end
                default: begin
                    state_nxt     = ST_CENTER;
                    react_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Motion is decided from the state held before this tick's transition.
    always_comb begin
        track_raw = $signed({1'b0, y_ball}) - TGT_OFS_S;
        track_tgt = track_raw;
        if (track_raw < 12'sd0) begin
            track_tgt = 12'sd0;
        end else if (track_raw > PAD_MAX_S) begin
            track_tgt = PAD_MAX_S;
        end

        target  = (state == ST_TRACK) ? track_tgt : CENTER_S;
        pad_s   = $signed({2'b00, y_pad_right});
        err     = target - pad_s;
        abs_err = err[11] ? -err : err;
        step    = (abs_err < SPEED_S) ? abs_err : SPEED_S;
        moved   = err[11] ? (pad_s - step) : (pad_s + step);

        moved_clamped = moved;
        if (moved < 12'sd0) begin
            moved_clamped = 12'sd0;
        end else if (moved > PAD_MAX_S) begin
            moved_clamped = PAD_MAX_S;
        end

        move_en = 1'b0;
        if (enable) begin
            case (state)
                ST_TRACK:  move_en = (abs_err > DEAD_S);
                ST_CENTER: move_en = (err != 12'sd0);
                default:   move_en = 1'b0;
            endcase
        end

        pad_nxt = move_en ? moved_clamped[9:0] : y_pad_right;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CENTER;
            react_cnt   <= '0;
            x_prev      <= 11'(X_PREV_RST);
            approaching <= 1'b0;
            y_pad_right <= 10'(CENTER_Y);
        end else if (timing_tick) begin
            state       <= state_nxt;
            react_cnt   <= react_cnt_nxt;
            x_prev      <= x_ball;
            approaching <= appr_nxt;
            y_pad_right <= pad_nxt;
        end
    end

endmodule

// File: tb/tb_pad_ai_controller.sv
// tb/tb_pad_ai_controller.sv - phase-table and scoreboard bench for pad_ai_controller
module tb_pad_ai_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        timing_tick;
    logic        enable;
    logic [10:0] x_ball;
    logic [10:0] y_ball;
    logic [9:0]  y_pad_right;
    logic        approaching;

    pad_ai_controller dut (
        .clk         (clk),
        .rst         (rst),
        .timing_tick (timing_tick),
        .enable      (enable),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .y_pad_right (y_pad_right),
        .approaching (approaching)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        int x_set;
        int x_step;
        int y;
        int n;
        int exp_pad;
        bit exp_appr;
    } phase_t;

    typedef struct {
        int pad;
        bit appr;
    } exp_t;

    phase_t ph_a[6];
    phase_t ph_b[4];
    exp_t   sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int x_cur    = 0;

    // Reference model: 0=CENTER 1=WAIT 2=TRACK
    int m_pad, m_xprev, m_state, m_cnt;
    bit m_appr;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_pad = 348; m_appr = 0; m_state = 0; m_xprev = 504; m_cnt = 0;
    endtask

    task automatic model_tick(input bit en, input int x, input int y);
        int  tgt, e, ae, st;
        bit  na;
        na = (x > m_xprev) ? 1'b1 : ((x < m_xprev) ? 1'b0 : m_appr);
        if (en && m_state != 1) begin
            tgt = (m_state == 2) ? clampi(y - 29, 0, 696) : 348;
            e   = tgt - m_pad;
            ae  = (e < 0) ? -e : e;
            if ((m_state == 2 && ae > 4) || (m_state == 0 && e != 0)) begin
                st    = (ae < 2) ? ae : 2;
                m_pad = clampi(m_pad + ((e > 0) ? st : -st), 0, 696);
            end
        end
        if (!en) begin
            m_state = 0; m_cnt = 0;
        end else if (m_state == 0) begin
            if (na && x >= 512) begin m_state = 1; m_cnt = 0; end
        end else if (m_state == 1) begin
            if (!na) m_state = 0;
            else if (m_cnt == 7) m_state = 2;
            else m_cnt++;
        end else begin
            if (!na) m_state = 0;
        end
        m_appr  = na;
        m_xprev = x;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic do_tick(input bit en, input int x, input int y);
        exp_t e;
        @(negedge clk);
        rst = 0; timing_tick = 1; enable = en;
        x_ball = 11'(x); y_ball = 11'(y);
        model_tick(en, x, y);
        sb_q.push_back('{pad: m_pad, appr: m_appr});
        @(posedge clk);
        #1;
        timing_tick = 0;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check("tick_pad", int'(y_pad_right), e.pad);
            check("tick_appr", int'(approaching), int'(e.appr));
        end
    endtask

    task automatic run_phase(input phase_t p, input string name);
        for (int i = 0; i < p.n; i++) begin
            if (i == 0 && p.x_set != 0) x_cur = p.x_set;
            else x_cur = x_cur + p.x_step;
            do_tick(p.en, x_cur, p.y);
        end
        check({name, "_end_pad"}, int'(y_pad_right), p.exp_pad);
        check({name, "_end_appr"}, int'(approaching), int'(p.exp_appr));
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst = 1; timing_tick = 1; enable = 1;
            x_ball = 11'($urandom_range(0, 2047)); y_ball = 11'($urandom_range(0, 2047));
        end
        @(posedge clk);
        #1;
        rst = 0; timing_tick = 0;
        model_reset();
        sb_q.delete();
        check("reset_pad", int'(y_pad_right), 348);
        check("reset_appr", int'(approaching), 0);
    endtask

    initial begin
        ph_a[0] = '{en: 1, x_set: 600, x_step:  2, y: 100, n:   8, exp_pad: 348, exp_appr: 1};
        ph_a[1] = '{en: 1, x_set:   0, x_step:  2, y: 100, n: 200, exp_pad:  74, exp_appr: 1};
        ph_a[2] = '{en: 1, x_set:   0, x_step:  1, y:   5, n:  50, exp_pad:   4, exp_appr: 1};
        ph_a[3] = '{en: 1, x_set:   0, x_step:  1, y: 760, n: 400, exp_pad: 692, exp_appr: 1};
        ph_a[4] = '{en: 1, x_set:   0, x_step:  1, y: 100, n: 350, exp_pad:  74, exp_appr: 1};
        ph_a[5] = '{en: 1, x_set:   0, x_step: -1, y: 100, n: 200, exp_pad: 348, exp_appr: 0};
        ph_b[0] = '{en: 1, x_set: 100, x_step:  2, y: 100, n:  20, exp_pad: 348, exp_appr: 1};
        ph_b[1] = '{en: 1, x_set: 600, x_step:  2, y: 100, n:  30, exp_pad: 306, exp_appr: 1};
        ph_b[2] = '{en: 0, x_set:   0, x_step:  2, y: 100, n:   5, exp_pad: 306, exp_appr: 1};
        ph_b[3] = '{en: 1, x_set:   0, x_step:  2, y: 100, n:  12, exp_pad: 302, exp_appr: 1};

        rst = 1; timing_tick = 0; enable = 1; x_ball = '0; y_ball = '0;
        model_reset();
        do_reset(2);

        foreach (ph_a[i]) run_phase(ph_a[i], $sformatf("phase_a%0d", i));

        // Inputs wander with no tick: nothing may change.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            timing_tick = 0;
            enable = 1'($urandom_range(0, 1));
            x_ball = 11'($urandom_range(0, 2047));
            y_ball = 11'($urandom_range(0, 2047));
            @(posedge clk);
            #1;
            check("notick_pad", int'(y_pad_right), m_pad);
            check("notick_appr", int'(approaching), int'(m_appr));
        end

        foreach (ph_b[i]) run_phase(ph_b[i], $sformatf("phase_b%0d", i));

        // Reset while tracking, then confirm x_prev restarted at 504.
        do_reset(1);
        do_tick(1, 500, 100);
        check("post_reset_appr", int'(approaching), 0);
        do_tick(1, 505, 100);
        check("post_reset_appr_rise", int'(approaching), 1);
        check("post_reset_pad", int'(y_pad_right), 348);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
